// File: rtl/shift_divider_pkg.sv
// div_pkg: shared types and constants for the shift_divider slice.
//   div_state_t : FSM state encoding (IDLE, SHIFT, SUB, DONE)
//   DIV_WIDTH   : operand width of the datapath
//   DIV_ITERS   : number of shift/subtract iterations per division
//   div_mag     : two's-complement magnitude helper used by the signed build
package div_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_ITERS = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SUB,
        DONE
    } div_state_t;

    // Magnitude of a two's-complement operand. The most negative value maps
    // to itself, which is still the correct unsigned magnitude (2^(N-1)).
    function automatic logic [DIV_WIDTH-1:0] div_mag(input logic [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? (~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/shift_divider_if.sv
// shift_divider_if: switch/button/result bundle shared between the divider
// and whatever drives it (top-level glue or a testbench).
//   Run      : start request, level-sensitive
//   Load_B   : load switch bus S into the divisor register
//   S        : switch bus (divisor on Load_B, dividend on start)
//   Q, R     : quotient and remainder registers
//   Busy     : division in progress
//   Done     : result valid, held until Run is released
//   Div_Zero : last division used a zero divisor
// Modports: master drives Run/Load_B/S, slave (the divider) drives results.
interface shift_divider_if;
    import div_pkg::*;

    logic                 Run;
    logic                 Load_B;
    logic [DIV_WIDTH-1:0] S;
    logic [DIV_WIDTH-1:0] Q;
    logic [DIV_WIDTH-1:0] R;
    logic                 Busy;
    logic                 Done;
    logic                 Div_Zero;

    modport master (
        output Run, Load_B, S,
        input  Q, R, Busy, Done, Div_Zero
    );

    modport slave (
        input  Run, Load_B, S,
        output Q, R, Busy, Done, Div_Zero
    );

endinterface

// File: rtl/shift_divider_trial_sub.sv
// div_trial_sub: WIDTH-bit trial subtractor, diff = a - b, with borrow out.
// Built as an adder with inverted b and carry-in 1, carries formed from
// generate/propagate terms in lookahead form.
//   a, b   : minuend and subtrahend
//   diff   : a - b (modulo 2^WIDTH)
//   borrow : 1 when b > a (inverted carry-out)
module div_trial_sub #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH-1:0] b_inv;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign b_inv = ~b;
    assign gen   = a & b_inv;
    assign prop  = a ^ b_inv;

    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign diff   = prop ^ carry[WIDTH-1:0];
    assign borrow = ~carry[WIDTH];

endmodule

// File: rtl/shift_divider.sv
// shift_divider: sequential restoring divider. Divides the dividend on S
// (captured at start) by the preloaded divisor register D, one SHIFT and one
// SUB state per quotient bit, 16 clocks from start edge to Done.
//   Clk   : system clock, rising edge
//   Reset : asynchronous active-high reset, clears all state
//   bus   : shift_divider_if.slave (Run, Load_B, S in; Q, R, Busy, Done,
//           Div_Zero out)
// Build option: define SIGNED_DIV_EN for two's-complement operands
// (truncating toward zero); undefined gives an unsigned-only divider.
module shift_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic            Clk,
    input  logic            Reset,
    shift_divider_if.slave  bus
);

    localparam int CNT_W = $clog2(DIV_ITERS);

    div_state_t       state;
    div_state_t       next_state;

    logic [WIDTH:0]   rx;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] count;
    logic             div_zero;

    logic [WIDTH-1:0] d_eff;
    logic [WIDTH-1:0] dividend_eff;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             last_iter;

    logic [WIDTH-1:0] q_sub;
    logic [WIDTH:0]   rx_sub;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH:0]   rx_final;

`ifdef SIGNED_DIV_EN
    logic             sign_a;
    logic             sign_b;

    // The core always iterates on magnitudes; signs are reapplied on the
    // last SUB so the corrected result lands in the same edge as DONE.
    assign d_eff        = div_mag(d);
    assign dividend_eff = div_mag(bus.S);

    always_comb begin
        q_final  = q_sub;
        rx_final = rx_sub;
        if ((sign_a ^ sign_b) && !div_zero) begin
            q_final = ~q_sub + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        if (sign_a) begin
            rx_final = ~rx_sub + {{WIDTH{1'b0}}, 1'b1};
        end
    end
`else
    assign d_eff        = d;
    assign dividend_eff = bus.S;

    always_comb begin
        q_final  = q_sub;
        rx_final = rx_sub;
    end
`endif

    div_trial_sub #(
        .WIDTH (WIDTH + 1)
    ) u_trial_sub (
        .a      (rx),
        .b      ({1'b0, d_eff}),
        .diff   (trial),
        .borrow (borrow)
    );

    // Restoring step: keep the trial remainder and set the quotient bit only
    // when the divisor fit.
    assign q_sub     = borrow ? q  : {q[WIDTH-1:1], 1'b1};
    assign rx_sub    = borrow ? rx : trial;
    assign last_iter = (count == CNT_W'(DIV_ITERS - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE waits for Run to drop so a held button never restarts a division.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.Run) next_state = SHIFT;
            SHIFT:   next_state = SUB;
            SUB:     next_state = last_iter ? DONE : SHIFT;
            DONE:    if (!bus.Run) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers. Run wins over Load_B in IDLE so the divisor used by
    // a starting division is never disturbed on its start edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx       <= '0;
            q        <= '0;
            d        <= '0;
            count    <= '0;
            div_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Run) begin
                        q        <= dividend_eff;
                        rx       <= '0;
                        count    <= '0;
                        div_zero <= (d == '0);
`ifdef SIGNED_DIV_EN
                        sign_a   <= bus.S[WIDTH-1];
                        sign_b   <= d[WIDTH-1];
`endif
                    end else if (bus.Load_B) begin
                        d <= bus.S;
                    end
                end
                SHIFT: begin
                    rx <= {rx[WIDTH-1:0], q[WIDTH-1]};
                    q  <= {q[WIDTH-2:0], 1'b0};
                end
                SUB: begin
                    count <= count + 1'b1;
                    if (last_iter) begin
                        q  <= q_final;
                        rx <= rx_final;
                    end else begin
                        q  <= q_sub;
                        rx <= rx_sub;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Q        = q;
    assign bus.R        = rx[WIDTH-1:0];
    assign bus.Busy     = (state == SHIFT) || (state == SUB);
    assign bus.Done     = (state == DONE);
    assign bus.Div_Zero = div_zero;

endmodule

// File: tb/tb_shift_divider.sv
// tb_shift_divider: directed self-checking bench for shift_divider.
// Drives inputs on the falling edge and samples there too, away from the
// rising edge the design uses.
module tb_shift_divider;

    logic Clk;
    logic Reset;
    int   tests_run;
    int   tests_failed;
    int   busy_cycles;
    bit   finished;

    shift_divider_if dut_if ();

    shift_divider dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (dut_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic run, input logic load_b, input logic [7:0] s);
        dut_if.Run    = run;
        dut_if.Load_B = load_b;
        dut_if.S      = s;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic loadDivisor(input logic [7:0] dv);
        applyStimulus(1'b0, 1'b1, dv);
        @(negedge Clk);
        applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    // Starts a division and waits (bounded) for Done, counting Busy cycles.
    // With inject_load set, pulses Load_B with S=9 while the FSM is in SUB.
    task automatic runDivision(input logic [7:0] dividend, input bit inject_load,
                               output int busy_n, output bit done_seen);
        busy_n    = 0;
        done_seen = 0;
        applyStimulus(1'b1, 1'b0, dividend);
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(negedge Clk);
            if (inject_load && c == 1) applyStimulus(1'b1, 1'b1, 8'd9);
            if (inject_load && c == 2) applyStimulus(1'b1, 1'b0, 8'd9);
            if (dut_if.Busy) busy_n++;
            if (dut_if.Done) done_seen = 1;
        end
    endtask

    task automatic releaseRun();
        applyStimulus(1'b0, 1'b0, 8'h00);
        @(negedge Clk);
    endtask

    task automatic checkResult(input string tag, input logic [7:0] exp_q, input logic [7:0] exp_r,
                               input logic exp_dz);
        checkOutput({tag, "_done"}, 16'(finished), 16'd1);
        checkOutput({tag, "_q"}, 16'(dut_if.Q), 16'(exp_q));
        checkOutput({tag, "_r"}, 16'(dut_if.R), 16'(exp_r));
        checkOutput({tag, "_divzero"}, 16'(dut_if.Div_Zero), 16'(exp_dz));
        checkOutput({tag, "_busy_at_done"}, 16'(dut_if.Busy), 16'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Reset        = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);

        #12;
        checkOutput("reset_q", 16'(dut_if.Q), 16'd0);
        checkOutput("reset_r", 16'(dut_if.R), 16'd0);
        checkOutput("reset_busy", 16'(dut_if.Busy), 16'd0);
        checkOutput("reset_done", 16'(dut_if.Done), 16'd0);
        checkOutput("reset_divzero", 16'(dut_if.Div_Zero), 16'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // 100 / 7 = 14 r 2, Busy for exactly 16 cycles
        loadDivisor(8'd7);
        runDivision(8'd100, 1'b0, busy_cycles, finished);
        checkResult("div100_7", 8'h0E, 8'h02, 1'b0);
        checkOutput("div100_7_busy_cycles", 16'(busy_cycles), 16'd16);
        releaseRun();
        checkOutput("release_done_low", 16'(dut_if.Done), 16'd0);
        checkOutput("idle_hold_q", 16'(dut_if.Q), 16'h0E);
        checkOutput("idle_hold_r", 16'(dut_if.R), 16'h02);

        // 254 / 255 (signed: -2 / -1 = 2 r 0)
        loadDivisor(8'd255);
        runDivision(8'd254, 1'b0, busy_cycles, finished);
`ifdef SIGNED_DIV_EN
        checkResult("div254_255", 8'd2, 8'd0, 1'b0);
`else
        checkResult("div254_255", 8'd0, 8'd254, 1'b0);
`endif
        releaseRun();

        // 255 / 1 (signed: -1 / 1 = -1 r 0, same bit patterns)
        loadDivisor(8'd1);
        runDivision(8'd255, 1'b0, busy_cycles, finished);
        checkResult("div255_1", 8'hFF, 8'h00, 1'b0);
        releaseRun();

        // Divide by zero, then a normal division clears Div_Zero
        loadDivisor(8'd0);
        runDivision(8'd7, 1'b0, busy_cycles, finished);
        checkResult("div7_0", 8'hFF, 8'h07, 1'b1);
        releaseRun();
        loadDivisor(8'd3);
        runDivision(8'd10, 1'b0, busy_cycles, finished);
        checkResult("div10_3", 8'd3, 8'd1, 1'b0);
        releaseRun();

        // Reset mid-division acts immediately, without a clock edge
        loadDivisor(8'd7);
        applyStimulus(1'b1, 1'b0, 8'd100);
        repeat (5) @(negedge Clk);
        checkOutput("mid_busy_before_reset", 16'(dut_if.Busy), 16'd1);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("midreset_q", 16'(dut_if.Q), 16'd0);
        checkOutput("midreset_r", 16'(dut_if.R), 16'd0);
        checkOutput("midreset_busy", 16'(dut_if.Busy), 16'd0);
        checkOutput("midreset_done", 16'(dut_if.Done), 16'd0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("post_reset_idle_busy", 16'(dut_if.Busy), 16'd0);
        loadDivisor(8'd7);
        runDivision(8'd100, 1'b0, busy_cycles, finished);
        checkResult("after_reset_div100_7", 8'h0E, 8'h02, 1'b0);
        checkOutput("after_reset_busy_cycles", 16'(busy_cycles), 16'd16);
        releaseRun();

        // Load_B during SUB is ignored; Run held through DONE never restarts
        runDivision(8'd100, 1'b1, busy_cycles, finished);
        checkResult("loadb_in_sub", 8'h0E, 8'h02, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            checkOutput("run_held_busy_done", {14'd0, dut_if.Busy, dut_if.Done}, 16'b01);
        end
        checkOutput("run_held_q", 16'(dut_if.Q), 16'h0E);
        releaseRun();
        // Divisor must still be 7: 21 / 7 = 3 r 0
        runDivision(8'd21, 1'b0, busy_cycles, finished);
        checkResult("div21_after_ignored_load", 8'd3, 8'd0, 1'b0);
        releaseRun();

        // 8'h9C / 7: unsigned 156/7 = 22 r 2; signed -100/7 = -14 r -2
        loadDivisor(8'd7);
        runDivision(8'h9C, 1'b0, busy_cycles, finished);
`ifdef SIGNED_DIV_EN
        checkResult("div9c_7", 8'hF2, 8'hFE, 1'b0);
`else
        checkResult("div9c_7", 8'd22, 8'd2, 1'b0);
`endif
        releaseRun();

`ifdef SIGNED_DIV_EN
        // -128 / -1 wraps to -128 r 0
        loadDivisor(8'hFF);
        runDivision(8'h80, 1'b0, busy_cycles, finished);
        checkResult("div80_ff", 8'h80, 8'h00, 1'b0);
        releaseRun();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
